// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU operation codes, the bubble opcode and the
// EX-stage control record used by the ID/EX pipeline register.
package cpu_defs_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b110;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  // A bubble drives the ALU to its zero-output operation.
  localparam logic [2:0] ALU_CTR_BUBBLE = ALU_ZERO;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [2:0] ctr;
  } ex_ctrl_t;

  // Register 0 is hardwired, so a write to it is never a forwarding source.
  function automatic logic addr_hit(input logic we, input logic [4:0] rd,
                                    input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux: picks the youngest in-flight result that targets
// the given source register, else the value read from the register file.
module fwd_unit
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] fwd_data
);

  // EX/MEM is checked first because it holds the more recent write.
  always_comb begin
    fwd_data = reg_data;
    if (addr_hit(exmem_reg_write, exmem_rd, src_addr)) begin
      fwd_data = exmem_result;
    end else if (addr_hit(memwb_reg_write, memwb_rd, src_addr)) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-side
// operand forwarding feeding the ALU operands A/B and ALU_Ctr.
module id_ex_stage
  import cpu_defs_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter logic [2:0] BUBBLE_CTR = ALU_CTR_BUBBLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_ctr,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_uses_rt,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        ALU_Ctr,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_id
);

  localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, reg_write: 1'b0,
                                       mem_read: 1'b0, mem_write: 1'b0,
                                       alu_src: 1'b0, rd: 5'd0, rs: 5'd0,
                                       rt: 5'd0, ctr: BUBBLE_CTR};

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              bubble;

  // A load in EX cannot forward its data yet; a flush overrides the stall.
  always_comb begin
    stall_id = !flush && ctrl_q.valid && ctrl_q.mem_read &&
               (ctrl_q.rd != 5'd0) && id_valid &&
               ((id_rs_addr == ctrl_q.rd) ||
                (id_uses_rt && (id_rt_addr == ctrl_q.rd)));
  end

  // Bubbles also clear addresses and data so forwarding cannot make A/B nonzero.
  always_comb begin
    bubble    = flush || stall_id || !id_valid;
    ctrl_d    = BUBBLE_CTRL;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    if (!bubble) begin
      ctrl_d.valid     = 1'b1;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.alu_src   = id_alu_src;
      ctrl_d.rd        = id_rd_addr;
      ctrl_d.rs        = id_rs_addr;
      ctrl_d.rt        = id_rt_addr;
      ctrl_d.ctr       = id_alu_ctr;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      imm_d            = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= BUBBLE_CTRL;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  fwd_unit #(.DATA_W(DATA_W)) u_fwd_rs (
    .src_addr        (ctrl_q.rs),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .fwd_data        (fwd_a)
  );

  fwd_unit #(.DATA_W(DATA_W)) u_fwd_rt (
    .src_addr        (ctrl_q.rt),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .fwd_data        (fwd_b)
  );

  assign A             = fwd_a;
  assign B             = ctrl_q.alu_src ? imm_q : fwd_b;
  assign ALU_Ctr       = ctrl_q.ctr;
  assign ex_store_data = fwd_b;
  assign ex_valid      = ctrl_q.valid;
  assign ex_rd         = ctrl_q.rd;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;

endmodule
